// File: rtl/seeg_pkg.sv
// Shared constants and types for the sEEG SPI responder.
// Opcodes, fixed result words and the chip-ID ROM.
package seeg_pkg;

  typedef enum logic [1:0] {
    OP_CONVERT = 2'b00,
    OP_CLEAR   = 2'b01,
    OP_WRITE   = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_COMMIT
  } state_e;

  localparam logic [31:0] CLEAR_WORD   = 32'h6A00_0000;
  localparam logic [15:0] CHIP_ID      = 16'h0020;
  localparam logic [15:0] WRITE_ACK_HI = 16'hFFFF;
  localparam logic [15:0] CONV_DC_BASE = 16'h0200;
  localparam logic [5:0]  FRAME_BITS   = 6'd32;
  localparam logic [5:0]  BIT_CNT_MAX  = 6'd63;

  localparam logic [7:0]  ROM_ADDR_0 = 8'd251;
  localparam logic [7:0]  ROM_ADDR_1 = 8'd252;
  localparam logic [7:0]  ROM_ADDR_2 = 8'd253;
  localparam logic [7:0]  ROM_ADDR_3 = 8'd254;
  localparam logic [7:0]  ROM_ADDR_4 = 8'd255;
  localparam logic [15:0] ROM_VAL_0  = 16'h0049;
  localparam logic [15:0] ROM_VAL_1  = 16'h004E;
  localparam logic [15:0] ROM_VAL_2  = 16'h0054;
  localparam logic [15:0] ROM_VAL_3  = 16'h0041;

  function automatic logic [15:0] rom_value(
    input logic [7:0] addr
  );
    case (addr)
      ROM_ADDR_0: rom_value = ROM_VAL_0;
      ROM_ADDR_1: rom_value = ROM_VAL_1;
      ROM_ADDR_2: rom_value = ROM_VAL_2;
      ROM_ADDR_3: rom_value = ROM_VAL_3;
      ROM_ADDR_4: rom_value = CHIP_ID;
      default:    rom_value = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with registered edge detect
// for one asynchronous SPI pin.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Chain resets low so a pin held low through reset
  // never produces a fall; it must first be seen high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/seeg_spi_responder.sv
// sEEG headstage SPI responder: 32-bit command frames in,
// results out two frames later, register file and counters.
module seeg_spi_responder
  import seeg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  output logic        frame_error
);

  localparam int AW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk   (clk),
    .rstn  (rstn),
    .din   (cs_n),
    .level (cs_lvl_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk   (clk),
    .rstn  (rstn),
    .din   (sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk   (clk),
    .rstn  (rstn),
    .din   (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_e      state, state_nxt;
  logic        fall_pend;
  logic [31:0] rx_sh, tx_sh;
  logic [31:0] res_a, res_b;
  logic [5:0]  bit_cnt;
  logic [15:0] regs [NUM_REGS];
  logic [11:0] cnt_ch [16];

  logic          start;
  op_e           op;
  logic [7:0]    addr;
  logic [3:0]    ch;
  logic [15:0]   data;
  logic [AW-1:0] idx;
  logic          addr_ok;
  logic          frame_ok;
  logic [15:0]   rd_val;
  logic [31:0]   result;
  logic          wr_en, conv_en, clr_en;

  assign start    = cs_fall | fall_pend;
  assign op       = op_e'(rx_sh[31:30]);
  assign addr     = rx_sh[23:16];
  assign ch       = rx_sh[19:16];
  assign data     = rx_sh[15:0];
  assign idx      = addr[AW-1:0];
  assign addr_ok  = int'(addr) < NUM_REGS;
  assign frame_ok = (bit_cnt == FRAME_BITS);
  assign rd_val   = addr_ok ? regs[idx] : rom_value(addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    result  = '0;
    wr_en   = 1'b0;
    conv_en = 1'b0;
    clr_en  = 1'b0;
    unique case (op)
      OP_CONVERT: begin
        result  = {ch, cnt_ch[ch],
                   CONV_DC_BASE + {12'd0, ch}};
        conv_en = 1'b1;
      end
      OP_WRITE: begin
        result = {WRITE_ACK_HI, data};
        wr_en  = addr_ok;
      end
      OP_READ:  result = {16'h0000, rd_val};
      OP_CLEAR: clr_en = (rx_sh == CLEAR_WORD);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso        <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_word    <= '0;
      frame_error <= 1'b0;
      fall_pend   <= 1'b0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      res_a       <= '0;
      res_b       <= '0;
      bit_cnt     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < 16; i++) cnt_ch[i] <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (start) begin
            miso      <= res_b[31];
            tx_sh     <= {res_b[30:0], 1'b0};
            rx_sh     <= '0;
            bit_cnt   <= '0;
            fall_pend <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (sclk_rise) begin
            rx_sh <= {rx_sh[30:0], mosi_lvl};
            if (bit_cnt != BIT_CNT_MAX)
              bit_cnt <= bit_cnt + 6'd1;
          end
          if (sclk_fall) begin
            miso  <= tx_sh[31];
            tx_sh <= {tx_sh[30:0], 1'b0};
          end
          if (cs_rise) miso <= 1'b0;
        end
        ST_COMMIT: begin
          miso <= 1'b0;
          if (cs_fall) fall_pend <= 1'b1;
          if (frame_ok) begin
            cmd_valid <= 1'b1;
            cmd_word  <= rx_sh;
            res_b     <= res_a;
            res_a     <= result;
            if (wr_en) regs[idx] <= data;
            if (conv_en) cnt_ch[ch] <= cnt_ch[ch] + 12'd1;
            if (clr_en)
              for (int i = 0; i < 16; i++) cnt_ch[i] <= '0;
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: miso <= 1'b0;
      endcase
    end
  end

endmodule
